// File: rtl/matrix_alu_stream.sv
// Streaming N x N matrix ALU: loads A (and B or a scalar) beat by beat,
// computes into C, then streams C out row-major under valid/ready.
module matrix_alu_stream #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   sel,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] eleIn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] eleOut,
    output logic         out_last,
    output logic         busy
);
    localparam int NN = N * N;
    localparam int CW = $clog2(NN + 1);
    localparam logic [CW-1:0] NL   = CW'(N);
    localparam logic [CW-1:0] NM1  = CW'(N - 1);
    localparam logic [CW-1:0] LAST = CW'(NN - 1);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_HAD   = 3'd3;
    localparam logic [2:0] OP_SCALE = 3'd4;
    localparam logic [2:0] OP_TRANS = 3'd5;

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] k_q, k_d;
    logic [W-1:0]  acc_q, acc_d;

    logic [W-1:0] a_q [NN];
    logic [W-1:0] b_q [NN];
    logic [W-1:0] c_q [NN];

    logic          in_beat, out_beat;
    logic          a_we, b_we, c_we;
    logic [W-1:0]  c_wd, res;
    logic          has_b;
    logic [CW-1:0] b_last;
    logic [CW-1:0] t_idx, am_idx, bm_idx;
    logic [W-1:0]  a_e, b_e, prod;

    assign in_ready  = ~reset & ((state_q == IDLE) | (state_q == LOAD_A) |
                                 (state_q == LOAD_B));
    assign in_beat   = in_valid & in_ready;
    assign out_valid = (state_q == OUTPUT);
    assign out_beat  = out_valid & out_ready;
    assign eleOut    = out_valid ? c_q[cnt_q] : '0;
    assign out_last  = out_valid & (cnt_q == LAST);
    assign busy      = (state_q != IDLE);

    assign t_idx  = col_q * NL + row_q;
    assign am_idx = row_q * NL + k_q;
    assign bm_idx = k_q * NL + col_q;
    assign a_e    = a_q[cnt_q];
    assign b_e    = b_q[cnt_q];
    assign prod   = a_q[am_idx] * b_q[bm_idx];

    always_comb begin
        has_b  = 1'b0;
        b_last = LAST;
        case (op_q)
            OP_ADD, OP_SUB, OP_MUL, OP_HAD: has_b = 1'b1;
            OP_SCALE: begin
                has_b  = 1'b1;
                b_last = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        res = a_e;
        case (op_q)
            OP_ADD:   res = a_e + b_e;
            OP_SUB:   res = a_e - b_e;
            OP_HAD:   res = a_e * b_e;
            OP_SCALE: res = a_e * b_q[0];
            OP_TRANS: res = a_q[t_idx];
            default:  res = a_e;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_we    = 1'b0;
        b_we    = 1'b0;
        c_we    = 1'b0;
        c_wd    = res;
        case (state_q)
            IDLE: begin
                row_d = '0;
                col_d = '0;
                k_d   = '0;
                cnt_d = '0;
                if (in_beat) begin
                    a_we    = 1'b1;
                    op_d    = sel;
                    cnt_d   = CW'(1);
                    state_d = LOAD_A;
                end
            end
            LOAD_A: if (in_beat) begin
                a_we = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = has_b ? LOAD_B : COMPUTE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOAD_B: if (in_beat) begin
                b_we = 1'b1;
                if (cnt_q == b_last) begin
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COMPUTE: begin
                // MUL spends N cycles per element, accumulating one MAC each
                if (op_q == OP_MUL) begin
                    acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
                    c_wd  = acc_d;
                    c_we  = (k_q == NM1);
                    k_d   = (k_q == NM1) ? '0 : k_q + CW'(1);
                end else begin
                    c_we = 1'b1;
                end
                if (c_we) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = OUTPUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (col_q == NM1) begin
                            col_d = '0;
                            row_d = row_q + CW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            OUTPUT: if (out_beat) begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            if (a_we) a_q[cnt_q] <= eleIn;
            if (b_we) b_q[cnt_q] <= eleIn;
            if (c_we) c_q[cnt_q] <= c_wd;
        end
    end
endmodule

// File: tb/tb_matrix_alu_stream.sv
// Scoreboard bench for matrix_alu_stream at N=3, W=32: directed operand
// sets with hand-computed results, checked by an independent output monitor.
module tb_matrix_alu_stream;
    typedef logic [31:0] v9_t [9];

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] eleIn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] eleOut;
    logic        out_last;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int nbeats = 0;
    int tbeat  = 0;
    logic [32:0] expq[$];
    logic        hold = 1'b0;
    logic [32:0] held;

    matrix_alu_stream #(.N(3), .W(32)) dut (
        .clk(clk), .reset(reset), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .eleIn(eleIn),
        .out_valid(out_valid), .out_ready(out_ready), .eleOut(eleOut),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: a beat happens at the edge following a negedge with valid&ready.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_data", eleOut, held[31:0]);
                chk("hold_last", {31'b0, out_last}, {31'b0, held[32]});
            end
            hold = out_valid && !out_ready;
            held = {out_last, eleOut};
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             eleOut);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", eleOut, e[31:0]);
                    chk("out_last", {31'b0, out_last}, {31'b0, e[32]});
                end
                nbeats++;
            end
        end
    end

    task automatic send(input logic [31:0] v, input int gap);
        int n = 0;
        eleIn    = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        tbeat = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input v9_t a, input v9_t b,
                          input int nb, input v9_t e, input int gap);
        for (int i = 0; i < 9; i++) expq.push_back({i == 8, e[i]});
        sel = op;
        for (int i = 0; i < 9; i++) begin
            send(a[i], gap);
            if (i == 0) sel = ~op;
        end
        for (int i = 0; i < nb; i++) send(b[i], gap);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_drained"}, expq.size(), 0);
        chk({nm, "_busy_low"}, {31'b0, busy}, 32'd0);
        chk({nm, "_valid_low"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic latency(input string nm, input int exp);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, cyc - tbeat, exp);
    endtask

    v9_t seq, rev, ones, zeros, ident, twos, tens, none;
    v9_t e_add, e_mul, e_sub, e_scl, e_tr, e_had, e_pass, e_add2, sc;
    int base, n;

    initial begin
        seq    = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        rev    = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        ones   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        zeros  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        ident  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        twos   = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        tens   = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        none   = zeros;
        sc     = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0};
        e_add  = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
        e_mul  = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        e_sub  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        e_scl  = '{32'h80000000, 0, 32'h80000000, 0, 32'h80000000,
                   0, 32'h80000000, 0, 32'h80000000};
        e_tr   = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
        e_had  = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
        e_pass = '{100, 101, 102, 103, 104, 105, 106, 107, 108};
        e_add2 = '{11, 22, 33, 44, 55, 66, 77, 88, 99};

        reset = 1'b1;
        sel = 3'd0;
        in_valid = 1'b0;
        eleIn = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_eleOut", eleOut, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        run_op(3'd0, seq, rev, 9, e_add, 0);
        drain("add");

        run_op(3'd2, seq, seq, 9, e_mul, 0);
        latency("mul_latency", 28);
        drain("mul");
        run_op(3'd2, seq, ident, 9, seq, 0);
        drain("mul_ident");

        run_op(3'd1, zeros, ones, 9, e_sub, 0);
        drain("sub");
        run_op(3'd4, seq, sc, 1, e_scl, 0);
        drain("scale");

        run_op(3'd5, seq, none, 0, e_tr, 0);
        chk("trans_in_ready", {31'b0, in_ready}, 32'd0);
        latency("trans_latency", 10);
        drain("trans");

        run_op(3'd3, seq, twos, 9, e_had, 1);
        drain("had_stall");

        base = nbeats;
        run_op(3'd6, e_pass, none, 0, e_pass, 0);
        n = 0;
        while (nbeats - base < 4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        chk("bp_idx4", eleOut, 32'd104);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("pass_bp");
        run_op(3'd7, rev, none, 0, rev, 0);
        drain("pass7");

        sel = 3'd2;
        for (int i = 0; i < 5; i++) send(seq[i], 0);
        chk("abort_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy_low", {31'b0, busy}, 32'd0);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_eleOut", eleOut, 32'd0);
        chk("abort_last", {31'b0, out_last}, 32'd0);
        chk("abort_idle", {31'b0, in_ready}, 32'd1);
        run_op(3'd0, seq, tens, 9, e_add2, 0);
        drain("add_after_abort");

        repeat (20) @(posedge clk);
        #1;
        chk("final_no_extra", nbeats, 90);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
